// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, frame timeout and byte FIFO.
// Optional macro PS2RX_PARITY_CHECK_EN: when defined, frames failing odd parity are dropped.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 48000,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  tri         ps2_clk,
    inout  tri         ps2_data,
    input  logic       samplen,
    input  logic       rden,
    output logic [7:0] q,
    output logic       dsr,
    output logic       overflow
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

`ifdef PS2RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Receive-only: the bus lines are released at all times.
    assign ps2_clk  = 1'bz;
    assign ps2_data = 1'bz;

    logic [1:0]        clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic              clk_filt_q, clk_filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        q_q, q_d;
    logic              dsr_q, dsr_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem_q [DEPTH];

    logic fall_c, push_c, pop_c, wr_en_c, drop_c, empty_c, full_c, data_bit_c;
    logic [DEPTH_LOG2-1:0] wr_idx_c, rd_idx_c;

    // Synchronizers and level filter; a fall is the filtered 1->0 change.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_filt_d  = clk_filt_q;
        fcnt_d      = '0;
        fall_c      = 1'b0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
                fall_c     = clk_filt_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign data_bit_c = data_sync_q[1];

    // Frame FSM with inactivity timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = '0;
        push_c    = 1'b0;
        if (!samplen) begin
            state_d = S_IDLE;
        end else begin
            if (state_q != S_IDLE) begin
                to_cnt_d = fall_c ? '0 : to_cnt_q + TO_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (fall_c && !data_bit_c) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (fall_c) begin
                        shift_d   = {data_bit_c, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall_c) begin
                        parity_d = data_bit_c;
                        state_d  = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall_c) begin
                        push_c  = data_bit_c && (!PAR_EN || ((^shift_q) ^ parity_q));
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (state_q != S_IDLE && !fall_c && to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                state_d  = S_IDLE;
                to_cnt_d = '0;
            end
        end
    end

    // FIFO control; a pop frees the slot a same-cycle push into a full FIFO uses.
    always_comb begin
        empty_c    = (wr_ptr_q == rd_ptr_q);
        full_c     = ((wr_ptr_q ^ rd_ptr_q) == PTR_W'(DEPTH));
        wr_idx_c   = wr_ptr_q[DEPTH_LOG2-1:0];
        rd_idx_c   = rd_ptr_q[DEPTH_LOG2-1:0];
        pop_c      = rden && !empty_c;
        wr_en_c    = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;
        wr_ptr_d   = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        q_d        = pop_c ? mem_q[rd_idx_c] : q_q;
        dsr_d      = (wr_ptr_d != rd_ptr_d);
        overflow_d = overflow_q;
        if (drop_c)     overflow_d = 1'b1;
        else if (pop_c) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            q_q         <= 8'h00;
            dsr_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_filt_q  <= clk_filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            q_q         <= q_d;
            dsr_q       <= dsr_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_idx_c] <= shift_q;
    end

    assign q        = q_q;
    assign dsr      = dsr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized self-checking bench for ps2_rx_fifo against a queue-based byte model.
module tb_ps2_rx_fifo;
    localparam int unsigned FL    = 8;
    localparam int unsigned TO    = 2000;
    localparam int unsigned DL    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned H     = 20;

`ifdef PS2RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic samplen = 1'b1;
    logic rden = 1'b0;
    logic ps2_clk_drv = 1'b1;
    logic ps2_data_drv = 1'b1;
    wire  ps2_clk_w;
    wire  ps2_data_w;
    logic [7:0] q;
    logic dsr, overflow;

    assign ps2_clk_w  = ps2_clk_drv;
    assign ps2_data_w = ps2_data_drv;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_q = 8'h00;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk_w), .ps2_data(ps2_data_w),
        .samplen(samplen), .rden(rden), .q(q), .dsr(dsr), .overflow(overflow)
    );

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_bad, input logic stop);
        return {stop, (~^d) ^ par_bad, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [10:0] bits, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            ps2_data_drv = bits[i];
            repeat (h) @(negedge clk);
            ps2_clk_drv = 1'b0;
            repeat (h) @(negedge clk);
            ps2_clk_drv = 1'b1;
        end
        repeat (h) @(negedge clk);
        ps2_data_drv = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic model_frame(input logic [10:0] f);
        if (f[10] && (!PAR_EN || (^f[9:1]))) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(f[8:1]);
        end
    endtask

    task automatic do_read();
        @(negedge clk); rden = 1'b1;
        @(negedge clk); rden = 1'b0;
        if (mq.size() > 0) begin
            m_q   = mq.pop_front();
            m_ovf = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL reset_dsr: got %b expected 0", dsr); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL post_reset_dsr: got %b expected 0", dsr); end
    endtask

    task automatic test_basic();
        logic [10:0] f;
        f = mk_frame(8'h1C, 1'b0, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        checks++; if (dsr !== 1'b1) begin errors++; $display("FAIL basic_dsr: got %b expected 1", dsr); end
        do_read();
        checks++; if (q !== 8'h1C) begin errors++; $display("FAIL basic_q: got %h expected 1c", q); end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL basic_dsr_after: got %b expected 0", dsr); end
    endtask

    task automatic test_parity();
        logic [10:0] f;
        logic [7:0]  exp_q;
        f = mk_frame(8'hF0, 1'b1, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        checks++; if (dsr !== !PAR_EN) begin errors++; $display("FAIL parity_dsr: got %b expected %b", dsr, !PAR_EN); end
        do_read();
        exp_q = PAR_EN ? 8'h1C : 8'hF0;
        checks++; if (q !== exp_q) begin errors++; $display("FAIL parity_q: got %h expected %h", q, exp_q); end
        f = mk_frame(8'h3C, 1'b0, 1'b0);
        send_frame(f, 11, H); model_frame(f);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL badstop_dsr: got %b expected 0", dsr); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            send_frame(mk_frame(8'(i), 1'b0, 1'b1), 11, H);
            model_frame(mk_frame(8'(i), 1'b0, 1'b1));
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (dsr !== 1'b1) begin errors++; $display("FAIL ovf_dsr: got %b expected 1", dsr); end
        for (int i = 1; i <= 8; i++) begin
            do_read();
            checks++; if (q !== 8'(i)) begin errors++; $display("FAIL ovf_q%0d: got %h expected %h", i, q, 8'(i)); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear%0d: got %b expected 0", i, overflow); end
        end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", dsr); end
        do_read();
        checks++; if (q !== 8'h08) begin errors++; $display("FAIL empty_read_q: got %h expected 08", q); end
    endtask

    task automatic test_timeout();
        logic [10:0] f;
        send_frame(mk_frame(8'h0F, 1'b0, 1'b1), 5, H);
        repeat (TO + 100) @(negedge clk);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL timeout_partial: got %b expected 0", dsr); end
        f = mk_frame(8'h5A, 1'b0, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        checks++; if (dsr !== 1'b1) begin errors++; $display("FAIL timeout_dsr: got %b expected 1", dsr); end
        do_read();
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL timeout_q: got %h expected 5a", q); end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL timeout_once: got %b expected 0", dsr); end
    endtask

    task automatic test_glitch_samplen();
        logic [10:0] f;
        ps2_data_drv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ps2_clk_drv = 1'b0;
            repeat ((i == 9) ? FL - 1 : 1) @(negedge clk);
            ps2_clk_drv = 1'b1;
            repeat (FL + 4) @(negedge clk);
        end
        ps2_data_drv = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL glitch_dsr: got %b expected 0", dsr); end
        f = mk_frame(8'h12, 1'b0, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        do_read();
        checks++; if (q !== 8'h12) begin errors++; $display("FAIL glitch_frame_q: got %h expected 12", q); end
        samplen = 1'b0;
        send_frame(f, 11, H);
        samplen = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL samplen_dsr: got %b expected 0", dsr); end
        checks++; if (q !== 8'h12) begin errors++; $display("FAIL samplen_q: got %h expected 12", q); end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] f;
        f = mk_frame(8'h77, 1'b0, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        send_frame(mk_frame(8'hA5, 1'b0, 1'b1), 6, H);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mq.delete(); m_q = 8'h00; m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL midreset_dsr: got %b expected 0", dsr); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL midreset_q: got %h expected 00", q); end
        f = mk_frame(8'h29, 1'b0, 1'b1);
        send_frame(f, 11, H); model_frame(f);
        do_read();
        checks++; if (q !== 8'h29) begin errors++; $display("FAIL midreset_new_q: got %h expected 29", q); end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL midreset_stale: got %b expected 0", dsr); end
    endtask

    task automatic test_random();
        logic [10:0] f;
        for (int n = 0; n < 24; n++) begin
            f = mk_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
            send_frame(f, 11, int'($urandom_range(12, 30)));
            model_frame(f);
            checks++; if (dsr !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_dsr%0d: got %b expected %b", n, dsr, mq.size() != 0); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf%0d: got %b expected %b", n, overflow, m_ovf); end
            if ($urandom_range(0, 2) != 0) begin
                do_read();
                checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_q%0d: got %h expected %h", n, q, m_q); end
            end
        end
        while (mq.size() > 0) begin
            do_read();
            checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_drain_q: got %h expected %h", q, m_q); end
        end
        checks++; if (dsr !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %b expected 0", dsr); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_end_ovf: got %b expected %b", overflow, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_overflow();
        test_timeout();
        test_glitch_samplen();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
